pll_reg_loader: RTL and testbench
=================================

PLL_REG_LOADER -- requirements
Module: pll_reg_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 24, serial word width in bits.
REQ-002 SHALL have parameter NUM_WORDS, default 4, number of words per load sequence (range 1..16).
REQ-003 SHALL have parameter GAP_CYC, default 4, idle clk cycles before each word.
REQ-004 SHALL have parameter SCK_DIV, default 2, clk cycles per sclk half-period (range 1 or more).
REQ-005 SHALL have parameter LOCK_TO, default 4096, clk cycles allowed for lock after the last word.
REQ-006 SHALL have parameter MAX_RETRY, default 3, maximum automatic reloads on lock timeout.
REQ-007 SHALL have port clk  in  1  single clock for all logic.
REQ-008 SHALL have port syncRst  in  1  reset, synchronous, active-high.
REQ-009 SHALL have port start  in  1  one-cycle reload request.
REQ-010 SHALL have port tblIdx  out  clog2(NUM_WORDS) (min 1)  index of the word being fetched.
REQ-011 SHALL have port tblData  in  WORD_W  word at tblIdx, valid combinationally in the same cycle.
REQ-012 SHALL have port lockDet  in  1  PLL lock indication, already synchronised to clk.
REQ-013 SHALL have port sdata  out  1  serial data, MSB first.
REQ-014 SHALL have port sclk  out  1  serial clock, idle low.
REQ-015 SHALL have port le  out  1  latch-enable pulse after each word.
REQ-016 SHALL have port busy, done and err, each out 1: sequence in progress, locked, and retries exhausted.
REQ-017 SHALL have port retryCnt  out  clog2(MAX_RETRY+1)  number of reloads used in the current attempt.

Function
REQ-018 SHALL implement the FSM states IDLE, GAP, LOAD, SHIFT, LATCH, WAIT_LOCK, DONE and ERR.
REQ-019 SHALL go from IDLE to GAP with idx=0 on the first cycle after reset is released (automatic power-up load).
REQ-020 SHALL stay in GAP for exactly GAP_CYC cycles with sclk=0, sdata=0 and le=0, then go to LOAD.
REQ-021 SHALL, in LOAD (1 cycle), capture tblData at tblIdx=idx into the shift register, then go to SHIFT.
REQ-022 SHALL, in SHIFT, present bit WORD_W-1 first and drive each bit for 2*SCK_DIV cycles (sclk low for SCK_DIV, then high for SCK_DIV), so SHIFT lasts WORD_W*2*SCK_DIV cycles.
REQ-023 SHALL keep sdata stable while sclk is high.
REQ-024 SHALL, in LATCH, drive le=1 for SCK_DIV cycles with sclk=0; then, if idx=NUM_WORDS-1, go to WAIT_LOCK, else increment idx and go to GAP.
REQ-025 SHALL, in WAIT_LOCK, count cycles and go to DONE on the first cycle lockDet=1.
REQ-026 SHALL, when the WAIT_LOCK count reaches LOCK_TO: if retryCnt<MAX_RETRY, increment retryCnt and restart at GAP with idx=0; otherwise go to ERR.
REQ-027 SHALL, in DONE, restart at GAP with idx=0 and retryCnt=0 if lockDet=0 for 2 consecutive cycles (loss of lock).
REQ-028 SHALL, on start=1 in DONE or ERR, restart at GAP with idx=0 and retryCnt=0.
REQ-029 SHALL ignore start in any other state.
REQ-030 SHALL drive busy=1 in GAP, LOAD, SHIFT, LATCH and WAIT_LOCK; done=1 only in DONE; err=1 only in ERR.
REQ-031 SHALL hold tblIdx at idx at all times.
REQ-032 SHALL make all outputs registered.
REQ-033 SHALL make NUM_WORDS=1 work, with WAIT_LOCK following the first LATCH.

Reset
REQ-034 SHALL, on syncRst=1, enter IDLE with idx=0, retryCnt=0, sclk=0, sdata=0, le=0, busy=0, done=0, err=0 and all counters cleared.
REQ-035 SHALL give syncRst priority over start and lockDet.
REQ-036 SHALL, on syncRst asserted mid-SHIFT, abort the word with no le pulse.

Structure
REQ-037 SHALL place the state enum, a clog2 helper and the default parameter constants in package pll_loader_pkg.
REQ-038 SHALL implement the serial shift, bit counting and sclk generation in sub-module spi_tx_shift (ports: load, data, sdata, sclk, doneBit); the FSM, gap, lock and retry logic stay in pll_reg_loader.

Verification
REQ-039 SHALL cover defaults with table {0x300009,0x8F8064,0x001401,0x001402}: after reset, 4 words appear MSB first on sdata, each 96 cycles long, 4 le pulses of 2 cycles, and busy=1 throughout.
REQ-040 SHALL cover lockDet=1 three cycles after the 4th le falls: done=1 on the next cycle, retryCnt=0.
REQ-041 SHALL cover lockDet held 0: exactly 3 reloads, each after 4096 WAIT_LOCK cycles, then err=1 and retryCnt=3; a start pulse then reloads with retryCnt=0.
REQ-042 SHALL cover in DONE: lockDet low for 1 cycle gives no reload; low for 2 cycles gives busy=1 and a new sequence from idx=0.
REQ-043 SHALL cover syncRst pulse during bit 10 of word 2: all outputs reset, no le pulse, and the sequence restarts from idx=0.
REQ-044 SHALL cover NUM_WORDS=1, WORD_W=8, SCK_DIV=1: one 16-cycle word, a 1-cycle le, then WAIT_LOCK; start asserted while busy has no effect.

Source files
------------

// File: rtl/pll_reg_loader_pkg.sv
// pll_loader_pkg: shared types and constants for the PLL register loader.
//   loaderStateT  - FSM state encoding (also exported on the debug port)
//   DEF_*         - default parameter values
//   clog2Min1()   - ceil(log2(n)) clamped to at least 1, for counter and port widths
package pll_loader_pkg;

  localparam int DEF_WORD_W    = 24;
  localparam int DEF_NUM_WORDS = 4;
  localparam int DEF_GAP_CYC   = 4;
  localparam int DEF_SCK_DIV   = 2;
  localparam int DEF_LOCK_TO   = 4096;
  localparam int DEF_MAX_RETRY = 3;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    LOAD,
    SHIFT,
    LATCH,
    WAIT_LOCK,
    DONE,
    ERR
  } loaderStateT;

  function automatic int clog2Min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_reg_loader_if.sv
// pll_reg_loader_if: word-table fetch port plus the three-wire serial bus to the PLL.
//   tblIdx  - index of the word being fetched (loader drives)
//   tblData - table word at tblIdx, valid combinationally in the same cycle
//   sdata   - serial data, MSB first
//   sclk    - serial clock, idle low
//   le      - latch-enable pulse after each word
// Handshake: there is no valid/ready pair. tblData is sampled by the loader on the
// single LOAD cycle of each word, and the PLL samples sdata on sclk rising edges and
// latches the word while le is high.
// WORD_W and NUM_WORDS must match the parameters of the attached pll_reg_loader.
interface pll_reg_loader_if
  import pll_loader_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS
);
  localparam int IDX_W = clog2Min1(NUM_WORDS);

  logic [IDX_W-1:0]  tblIdx;
  logic [WORD_W-1:0] tblData;
  logic              sdata;
  logic              sclk;
  logic              le;

  modport master (output tblIdx, input tblData, output sdata, output sclk, output le);
  modport slave  (input tblIdx, output tblData, input sdata, input sclk, input le);
endinterface

// File: rtl/pll_reg_loader_shift.sv
// spi_tx_shift: serialises one word, MSB first.
//   clk, syncRst - clock and synchronous active-high reset
//   load         - capture data and start shifting on the next cycle
//   data         - word to send
//   sdata        - serial data (MSB of the shift register, so it is a flop output)
//   sclk         - SCK_DIV cycles low then SCK_DIV cycles high per bit
//   doneBit      - high during the final cycle of the word
// Zeros shift in behind the data, so sdata returns to 0 once the word is out.
module spi_tx_shift
  import pll_loader_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int SCK_DIV = DEF_SCK_DIV
) (
  input  logic              clk,
  input  logic              syncRst,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  output logic              sdata,
  output logic              sclk,
  output logic              doneBit
);
  localparam int DIV_W = clog2Min1(SCK_DIV);
  localparam int BIT_W = clog2Min1(WORD_W);

  logic [WORD_W-1:0] shreg;
  logic              active;
  logic [DIV_W-1:0]  divCnt;
  logic [BIT_W-1:0]  bitCnt;
  logic              halfEnd;
  logic              lastBit;

  assign halfEnd = (divCnt == DIV_W'(SCK_DIV - 1));
  assign lastBit = (bitCnt == BIT_W'(WORD_W - 1));
  assign sdata   = shreg[WORD_W-1];
  assign doneBit = active & sclk & halfEnd & lastBit;

  always_ff @(posedge clk) begin
    if (syncRst) begin
      shreg  <= '0;
      active <= 1'b0;
      sclk   <= 1'b0;
      divCnt <= '0;
      bitCnt <= '0;
    end else if (load) begin
      shreg  <= data;
      active <= 1'b1;
      sclk   <= 1'b0;
      divCnt <= '0;
      bitCnt <= '0;
    end else if (active) begin
      if (halfEnd) begin
        divCnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          // Data only moves at the end of the high half, keeping sdata stable while sclk=1.
          sclk   <= 1'b0;
          shreg  <= shreg << 1;
          bitCnt <= bitCnt + BIT_W'(1);
          if (lastBit) active <= 1'b0;
        end
      end else begin
        divCnt <= divCnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/pll_reg_loader.sv
// pll_reg_loader: loads NUM_WORDS table words into a PLL over a three-wire serial bus,
// waits for lock, reloads on lock timeout (up to MAX_RETRY times) and on loss of lock.
//   clk, syncRst - clock and synchronous active-high reset
//   start        - one-cycle reload request, honoured only in DONE or ERR
//   lockDet      - PLL lock, already synchronised to clk
//   bus          - table fetch + serial bus (pll_reg_loader_if master)
//   busy/done/err- loading in progress / locked / retries exhausted
//   retryCnt     - reloads used in the current attempt
//   dbgState     - current FSM state
// GAP_CYC and SCK_DIV must be at least 1.
module pll_reg_loader
  import pll_loader_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int SCK_DIV   = DEF_SCK_DIV,
  parameter int LOCK_TO   = DEF_LOCK_TO,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic                                 clk,
  input  logic                                 syncRst,
  input  logic                                 start,
  input  logic                                 lockDet,
  pll_reg_loader_if.master                     bus,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic [clog2Min1(MAX_RETRY+1)-1:0]    retryCnt,
  output loaderStateT                          dbgState
);
  localparam int IDX_W   = clog2Min1(NUM_WORDS);
  localparam int RTY_W   = clog2Min1(MAX_RETRY + 1);
  localparam int MAX_A   = (GAP_CYC > SCK_DIV) ? GAP_CYC : SCK_DIV;
  localparam int CNT_MAX = (LOCK_TO > MAX_A) ? LOCK_TO : MAX_A;
  localparam int CNT_W   = clog2Min1(CNT_MAX + 1);

  loaderStateT      state;
  logic [IDX_W-1:0] idx;
  // Shared cycle counter: gap length, le width, lock timeout, and in DONE the
  // number of consecutive lockDet=0 cycles seen so far.
  logic [CNT_W-1:0] cnt;
  logic             le;
  logic             restartReq;
  logic             shLoad;
  logic             shDone;
  logic             shSdata;
  logic             shSclk;

  assign shLoad = (state == LOAD);

  spi_tx_shift #(
    .WORD_W (WORD_W),
    .SCK_DIV(SCK_DIV)
  ) u_shift (
    .clk    (clk),
    .syncRst(syncRst),
    .load   (shLoad),
    .data   (bus.tblData),
    .sdata  (shSdata),
    .sclk   (shSclk),
    .doneBit(shDone)
  );

  assign bus.tblIdx = idx;
  assign bus.sdata  = shSdata;
  assign bus.sclk   = shSclk;
  assign bus.le     = le;
  assign dbgState   = state;

  // Full reload from word 0 with a fresh retry budget.
  always_comb begin
    restartReq = 1'b0;
    if (state == DONE)     restartReq = start || (!lockDet && cnt == CNT_W'(1));
    else if (state == ERR) restartReq = start;
  end

  always_ff @(posedge clk) begin
    if (syncRst) begin
      state    <= IDLE;
      idx      <= '0;
      retryCnt <= '0;
      cnt      <= '0;
      le       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else if (restartReq) begin
      state    <= GAP;
      idx      <= '0;
      retryCnt <= '0;
      cnt      <= '0;
      busy     <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= GAP;
          idx   <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        GAP: begin
          if (cnt == CNT_W'(GAP_CYC - 1)) begin
            state <= LOAD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LOAD: state <= SHIFT;
        SHIFT: begin
          if (shDone) begin
            state <= LATCH;
            le    <= 1'b1;
            cnt   <= '0;
          end
        end
        LATCH: begin
          if (cnt == CNT_W'(SCK_DIV - 1)) begin
            le  <= 1'b0;
            cnt <= '0;
            if (idx == IDX_W'(NUM_WORDS - 1)) begin
              state <= WAIT_LOCK;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= GAP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lockDet) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
          end else if (cnt == CNT_W'(LOCK_TO - 1)) begin
            cnt <= '0;
            if (retryCnt < RTY_W'(MAX_RETRY)) begin
              retryCnt <= retryCnt + RTY_W'(1);
              idx      <= '0;
              state    <= GAP;
            end else begin
              state <= ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // A single low cycle is tolerated; the second consecutive one triggers restartReq.
          cnt <= lockDet ? '0 : CNT_W'(1);
        end
        ERR: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reg_loader.sv
module tb_pll_reg_loader;
  import pll_loader_pkg::*;

  localparam int TB_GAP     = 4;
  localparam int TB_LOCK_TO = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic syncRstA = 1'b1, syncRstB = 1'b1;
  logic startA = 1'b0, startB = 1'b0;
  logic lockDetA = 1'b0, lockDetB = 1'b0;

  // DUT A: default parameters
  logic        busyA, doneA, errA;
  logic [1:0]  retryA;
  loaderStateT dbgA;
  logic [23:0] tblA [4];
  pll_reg_loader_if #(.WORD_W(24), .NUM_WORDS(4)) busA ();
  assign busA.tblData = tblA[busA.tblIdx];

  pll_reg_loader dutA (
    .clk(clk), .syncRst(syncRstA), .start(startA), .lockDet(lockDetA), .bus(busA),
    .busy(busyA), .done(doneA), .err(errA), .retryCnt(retryA), .dbgState(dbgA)
  );

  // DUT B: one 8-bit word, SCK_DIV=1
  logic        busyB, doneB, errB;
  logic [1:0]  retryB;
  loaderStateT dbgB;
  logic [7:0]  tblB;
  pll_reg_loader_if #(.WORD_W(8), .NUM_WORDS(1)) busB ();
  assign busB.tblData = tblB;

  pll_reg_loader #(.WORD_W(8), .NUM_WORDS(1), .SCK_DIV(1)) dutB (
    .clk(clk), .syncRst(syncRstB), .start(startB), .lockDet(lockDetB), .bus(busB),
    .busy(busyB), .done(doneB), .err(errB), .retryCnt(retryB), .dbgState(dbgB)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];  // per-cycle {idx[3:0], sclk, sdata, le, busy}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] obs_vec(input int d);
    if (d == 0) return {2'b00, busA.tblIdx, busA.sclk, busA.sdata, busA.le, busyA};
    else        return {3'b000, busB.tblIdx, busB.sclk, busB.sdata, busB.le, busyB};
  endfunction

  function automatic logic [31:0] tbl_word(input int d, input int w);
    if (d == 0) return 32'(tblA[w]);
    else        return 32'(tblB);
  endfunction

  function automatic logic [7:0] mk(input int w, input logic sc, input logic sd, input logic l);
    logic [3:0] wi;
    wi = 4'(w);
    return {wi, sc, sd, l, 1'b1};
  endfunction

  // Reference waveform of one load sequence, from the first GAP cycle to the end of the last LATCH.
  task automatic build_exp(input int d, input int nWords, input int wordW, input int div);
    logic [31:0] word;
    exp_q.delete();
    for (int w = 0; w < nWords; w++) begin
      word = tbl_word(d, w);
      for (int c = 0; c < TB_GAP + 1; c++) exp_q.push_back(mk(w, 1'b0, 1'b0, 1'b0));
      for (int b = wordW - 1; b >= 0; b--) begin
        for (int c = 0; c < div; c++) exp_q.push_back(mk(w, 1'b0, word[b], 1'b0));
        for (int c = 0; c < div; c++) exp_q.push_back(mk(w, 1'b1, word[b], 1'b0));
      end
      for (int c = 0; c < div; c++) exp_q.push_back(mk(w, 1'b0, 1'b0, 1'b1));
    end
  endtask

  // Walks exp_q one cycle per negedge starting now. Per word: cycle trace, word
  // recovered from sclk rising edges, and le width. limit<0 runs the whole queue.
  task automatic run_trace(input int d, input int wordW, input int div,
                           input int limit, input int startAt);
    int segLen, i, mism, firstBad, leCnt;
    logic [31:0] cap, mask, word;
    logic prevSclk;
    logic [7:0] o, e;
    segLen = TB_GAP + 1 + 2 * div * wordW + div;
    mask = (wordW >= 32) ? 32'hFFFF_FFFF : ((32'd1 << wordW) - 32'd1);
    i = 0; mism = 0; firstBad = -1; leCnt = 0; cap = '0; prevSclk = 1'b0;
    while (exp_q.size() > 0 && (limit < 0 || i < limit)) begin
      if (d == 0) startA = (i == startAt); else startB = (i == startAt);
      e = exp_q.pop_front();
      o = obs_vec(d);
      if (o !== e) begin
        if (firstBad < 0) firstBad = i % segLen;
        mism++;
      end
      if (o[3] && !prevSclk) cap = {cap[30:0], o[2]};
      prevSclk = o[3];
      if (o[1]) leCnt++;
      if ((i + 1) % segLen == 0) begin
        word = tbl_word(d, i / segLen);
        check($sformatf("trace d%0d w%0d badcycles(first@%0d)", d, i / segLen, firstBad), mism, 0);
        check($sformatf("word d%0d w%0d", d, i / segLen), cap & mask, word & mask);
        check($sformatf("le_width d%0d w%0d", d, i / segLen), leCnt, div);
        mism = 0; firstBad = -1; leCnt = 0; cap = '0;
      end
      i++;
      @(negedge clk);
    end
    startA = 1'b0;
    startB = 1'b0;
    exp_q.delete();
  endtask

  task automatic rand_table_a();
    for (int k = 0; k < 4; k++) tblA[k] = 24'($urandom());
  endtask

  // Counts WAIT_LOCK cycles from now; bounded so a stuck DUT still reaches the summary.
  task automatic wait_len_a(output int n);
    n = 0;
    while (dbgA == WAIT_LOCK && n < TB_LOCK_TO + 16) begin
      n++;
      @(negedge clk);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, dly, limit;
    tblA[0] = 24'h300009; tblA[1] = 24'h8F8064; tblA[2] = 24'h001401; tblA[3] = 24'h001402;
    tblB = 8'($urandom());

    repeat (3) @(negedge clk);
    check("reset_outputs_a", {busA.tblIdx, busA.sclk, busA.sdata, busA.le, busyA, doneA, errA, retryA}, 0);
    check("reset_state_a", 64'(dbgA), 64'(IDLE));

    // power-up load with the fixed table
    syncRstA = 1'b0;
    @(negedge clk);
    build_exp(0, 4, 24, 2);
    run_trace(0, 24, 2, -1, -1);
    check("wait_lock_entry", 64'(dbgA), 64'(WAIT_LOCK));
    check("busy_in_wait_lock", busyA, 1);

    // lock three cycles after the last le
    repeat (2) @(negedge clk);
    lockDetA = 1'b1;
    @(negedge clk);
    check("done_after_lock", {doneA, busyA, errA}, 3'b100);
    check("retry_after_lock", retryA, 0);

    // one-cycle lock glitch is tolerated
    lockDetA = 1'b0;
    @(negedge clk);
    lockDetA = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_keeps_done", {doneA, busyA}, 2'b10);

    // two-cycle loss of lock reloads from word 0
    rand_table_a();
    lockDetA = 1'b0;
    @(negedge clk);
    check("loss_1cyc_still_done", doneA, 1);
    @(negedge clk);
    check("loss_reload", {busyA, doneA, busA.tblIdx}, {1'b1, 1'b0, 2'd0});
    build_exp(0, 4, 24, 2);
    run_trace(0, 24, 2, -1, -1);

    // lockDet held low: three timed-out reloads, then ERR
    for (int k = 1; k <= 4; k++) begin
      wait_len_a(n);
      check($sformatf("wait_lock_len %0d", k), n, TB_LOCK_TO);
      if (k <= 3) begin
        check($sformatf("retry_cnt %0d", k), retryA, k);
        check($sformatf("retry_gap %0d", k), {64'(dbgA), 64'(busA.tblIdx)}, {64'(GAP), 64'd0});
        rand_table_a();
        build_exp(0, 4, 24, 2);
        run_trace(0, 24, 2, -1, -1);
      end else begin
        check("err_flags", {errA, busyA, doneA}, 3'b100);
        check("err_retry", retryA, 3);
      end
    end

    // start in ERR reloads with a fresh retry budget
    repeat (5) @(negedge clk);
    check("err_holds", 64'(dbgA), 64'(ERR));
    rand_table_a();
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    check("start_from_err", {errA, busyA, retryA}, {1'b0, 1'b1, 2'd0});

    // reset during bit 10 of word 2
    build_exp(0, 4, 24, 2);
    limit = 2 * (TB_GAP + 1 + 2 * 2 * 24 + 2) + (TB_GAP + 1) + 10 * 2 * 2 + 1;
    run_trace(0, 24, 2, limit, -1);
    syncRstA = 1'b1;
    @(negedge clk);
    check("midshift_reset_outputs", {busA.tblIdx, busA.sclk, busA.sdata, busA.le, busyA, doneA, errA, retryA}, 0);
    check("midshift_reset_state", 64'(dbgA), 64'(IDLE));
    syncRstA = 1'b0;
    @(negedge clk);
    check("restart_after_reset", {64'(dbgA), 64'(busA.tblIdx)}, {64'(GAP), 64'd0});
    build_exp(0, 4, 24, 2);
    run_trace(0, 24, 2, -1, -1);
    dly = $urandom_range(0, 20);
    repeat (dly) @(negedge clk);
    lockDetA = 1'b1;
    @(negedge clk);
    check("done_random_delay", {doneA, busyA, retryA}, {1'b1, 1'b0, 2'd0});

    // DUT B: single 8-bit word, start pulses while busy are ignored
    check("reset_outputs_b", {busB.sclk, busB.sdata, busB.le, busyB, doneB, errB}, 0);
    syncRstB = 1'b0;
    @(negedge clk);
    build_exp(1, 1, 8, 1);
    run_trace(1, 8, 1, -1, 10);
    check("b_wait_lock", {64'(dbgB), 64'(busyB)}, {64'(WAIT_LOCK), 64'd1});
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    check("b_start_ignored", 64'(dbgB), 64'(WAIT_LOCK));
    lockDetB = 1'b1;
    @(negedge clk);
    check("b_done", {doneB, busyB}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
